// File: rtl/reg_bank4.sv
// reg_bank4: four-entry register bank, one-hot write select, two registered
// read ports, sequenced clear. Option macro: REG_BANK_BYPASS_EN (write forwarding).
module reg_bank4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [3:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             clr,
    input  logic [1:0]       rd_addr_a,
    input  logic [1:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             sel_err,
    output logic [7:0]       wr_count
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       clr_idx_q;
    logic [1:0]       clr_idx_d;
    logic [WIDTH-1:0] regs_q [4];
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;
    logic             wr_fire;
    logic             sel_onehot;
    logic             wr_ok;
    logic             wr_bad;

    // a pending clear request blocks writes in the same cycle
    assign wr_ready   = rst_n && (state_q == IDLE) && !clr;
    assign wr_fire    = wr_valid && wr_ready;
    assign sel_onehot = (wr_sel != 4'b0000) &&
                        ((wr_sel & (wr_sel - 4'd1)) == 4'b0000);
    assign wr_ok      = wr_fire && sel_onehot;
    assign wr_bad     = wr_fire && !sel_onehot;

    // next-state logic: clear walks clr_idx 0..3, clr is ignored while clearing
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d   = CLEAR;
                    clr_idx_d = 2'd0;
                end
            end
            CLEAR: begin
                clr_idx_d = clr_idx_q + 2'd1;
                if (clr_idx_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // register array: clear sweep or one-hot write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            regs_q[clr_idx_q] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    // read mux; clear zeroing is never forwarded, only real writes
    always_comb begin
        rd_next_a = regs_q[rd_addr_a];
        rd_next_b = regs_q[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
        if (wr_ok && wr_sel[rd_addr_a]) begin
            rd_next_a = wr_data;
        end
        if (wr_ok && wr_sel[rd_addr_b]) begin
            rd_next_b = wr_data;
        end
`endif
    end

    // registered read ports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= rd_next_a;
            rd_data_b <= rd_next_b;
        end
    end

    // write counter and sticky select error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count <= 8'd0;
            sel_err  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_count <= wr_count + 8'd1;
            end
            if (wr_bad) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule
